// File: rtl/mouse_pkg.sv
// mouse_pkg: PS/2 mouse command/response bytes, controller state encoding
// and the per-axis delta formatting helper.
`default_nettype none

package mouse_pkg;

  localparam logic [7:0] MOUSE_CMD_RESET  = 8'hFF;
  localparam logic [7:0] MOUSE_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] MOUSE_ACK        = 8'hFA;
  localparam logic [7:0] MOUSE_BAT_OK     = 8'hAA;
  localparam logic [7:0] MOUSE_ID_STD     = 8'h00;

  typedef enum logic [3:0] {
    S_SEND_RST     = 4'd0,
    S_WAIT_ACK_RST = 4'd1,
    S_WAIT_BAT     = 4'd2,
    S_WAIT_ID      = 4'd3,
    S_SEND_EN      = 4'd4,
    S_WAIT_ACK_EN  = 4'd5,
    S_B0           = 4'd6,
    S_B1           = 4'd7,
    S_B2           = 4'd8,
    S_ERROR        = 4'd9
  } mouse_state_t;

  // Saturates to +255 / -256 when clamping is on and the overflow flag is set.
  function automatic logic [8:0] axis_value(input logic sign, input logic ovf,
                                            input logic [7:0] mag, input logic clamp);
    if (clamp && ovf) return sign ? 9'h100 : 9'h0FF;
    return {sign, mag};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mouse_timer.sv
// mouse_timer: loadable down-counter; expired is high while enabled at zero.
`default_nettype none

module mouse_timer #(
  parameter int WIDTH = 26,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             restart,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= INIT;
    end else if (restart) begin
      r_count <= load_value;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = enable && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mouse_packet_ctrl.sv
// mouse_packet_ctrl: PS/2 mouse init sequencer and 3-byte stream packet assembler.
// Optional MOUSE_OVF_CLAMP_EN saturates an axis whose overflow flag is set.
`default_nettype none

module mouse_packet_ctrl
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int PKT_GAP_CYCLES = 1_000_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_req,
  input  logic       tx_done,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       m1,
  output logic       m2,
  output logic       m3,
  output logic       new_data,
  output logic       ready,
  output logic       error
);

`ifdef MOUSE_OVF_CLAMP_EN
  localparam logic OVF_CLAMP = 1'b1;
`else
  localparam logic OVF_CLAMP = 1'b0;
`endif

  localparam int TMAX = (TIMEOUT_CYCLES > PKT_GAP_CYCLES) ? TIMEOUT_CYCLES : PKT_GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] INIT_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(PKT_GAP_CYCLES - 1);
  localparam logic [RW-1:0] LAST_RETRY = RW'(MAX_RETRIES - 1);

  mouse_state_t r_state;
  mouse_state_t w_next;
  logic [7:0]   w_expect;
  logic         w_wait;
  logic         w_fail;
  logic         w_send_state;
  logic         w_restart;
  logic         w_stream_load;
  logic         w_expired;
  logic [TW-1:0] w_load;
  logic [RW-1:0] r_retries;
  // Header bits kept: {ovfY, ovfX, signY, signX, mid, right, left}.
  logic [6:0]   r_hdr;
  logic [7:0]   r_xbyte;

  always_comb begin
    w_expect = MOUSE_ACK;
    w_next   = S_WAIT_BAT;
    w_wait   = 1'b1;
    case (r_state)
      S_WAIT_ACK_RST: begin w_expect = MOUSE_ACK;    w_next = S_WAIT_BAT; end
      S_WAIT_BAT:     begin w_expect = MOUSE_BAT_OK; w_next = S_WAIT_ID;  end
      S_WAIT_ID:      begin w_expect = MOUSE_ID_STD; w_next = S_SEND_EN;  end
      S_WAIT_ACK_EN:  begin w_expect = MOUSE_ACK;    w_next = S_B0;       end
      default:        w_wait = 1'b0;
    endcase
  end

  assign w_fail       = w_wait && (rx_valid ? (rx_byte != w_expect) : w_expired);
  assign w_send_state = (r_state == S_SEND_RST) || (r_state == S_SEND_EN);
  // Reload on any state change or received byte, so the count always belongs to the next state.
  assign w_restart    = w_send_state ? (tx_done && tx_req) : (rx_valid || w_expired);
  assign w_stream_load = ((r_state == S_B0) && !(rx_valid && (rx_byte == MOUSE_BAT_OK))) ||
                         (r_state == S_B1) || (r_state == S_B2);
  assign w_load       = w_stream_load ? GAP_LOAD : INIT_LOAD;

  mouse_timer #(
    .WIDTH (TW),
    .INIT  (INIT_LOAD)
  ) u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .restart    (w_restart),
    .enable     (!w_send_state),
    .load_value (w_load),
    .expired    (w_expired)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_SEND_RST;
      r_retries <= '0;
      r_hdr     <= '0;
      r_xbyte   <= '0;
      tx_req    <= 1'b0;
      tx_byte   <= 8'h00;
      dx        <= '0;
      dy        <= '0;
      m1        <= 1'b0;
      m2        <= 1'b0;
      m3        <= 1'b0;
      new_data  <= 1'b0;
      ready     <= 1'b0;
      error     <= 1'b0;
    end else begin
      new_data <= 1'b0;
      case (r_state)
        S_SEND_RST: begin
          tx_byte <= MOUSE_CMD_RESET;
          if (tx_req && tx_done) begin
            tx_req  <= 1'b0;
            r_state <= S_WAIT_ACK_RST;
          end else begin
            tx_req <= 1'b1;
          end
        end
        S_SEND_EN: begin
          tx_byte <= MOUSE_CMD_ENABLE;
          if (tx_req && tx_done) begin
            tx_req  <= 1'b0;
            r_state <= S_WAIT_ACK_EN;
          end else begin
            tx_req <= 1'b1;
          end
        end
        S_WAIT_ACK_RST, S_WAIT_BAT, S_WAIT_ID, S_WAIT_ACK_EN: begin
          if (w_fail) begin
            if (r_retries == LAST_RETRY) begin
              r_state <= S_ERROR;
              error   <= 1'b1;
            end else begin
              r_retries <= r_retries + 1'b1;
              r_state   <= S_SEND_RST;
            end
          end else if (rx_valid) begin
            r_state <= w_next;
            if (r_state == S_WAIT_ACK_EN) begin
              ready     <= 1'b1;
              r_retries <= '0;
            end
          end
        end
        S_B0: begin
          if (rx_valid) begin
            if (rx_byte == MOUSE_BAT_OK) begin
              r_state <= S_WAIT_ID;
              ready   <= 1'b0;
              m1      <= 1'b0;
              m2      <= 1'b0;
              m3      <= 1'b0;
            end else if (rx_byte[3]) begin
              r_hdr   <= {rx_byte[7:4], rx_byte[2:0]};
              r_state <= S_B1;
            end
          end
        end
        S_B1: begin
          if (rx_valid) begin
            r_xbyte <= rx_byte;
            r_state <= S_B2;
          end else if (w_expired) begin
            r_state <= S_B0;
          end
        end
        S_B2: begin
          if (rx_valid) begin
            dx       <= axis_value(r_hdr[3], r_hdr[5], r_xbyte, OVF_CLAMP);
            dy       <= axis_value(r_hdr[4], r_hdr[6], rx_byte, OVF_CLAMP);
            m1       <= r_hdr[0];
            m2       <= r_hdr[1];
            m3       <= r_hdr[2];
            new_data <= 1'b1;
            r_state  <= S_B0;
          end else if (w_expired) begin
            r_state <= S_B0;
          end
        end
        S_ERROR: begin
          tx_req <= 1'b0;
        end
        default: begin
          r_state <= S_SEND_RST;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mouse_packet_ctrl.sv
// tb_mouse_packet_ctrl: directed bench with a simple transceiver model and packet vector table.
`default_nettype none

module tb_mouse_packet_ctrl;

  localparam int T_CYC   = 40;
  localparam int G_CYC   = 20;
  localparam int RETRIES = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_req;
  logic [8:0] dx, dy;
  logic       m1, m2, m3, new_data, ready, error;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic [7:0] sent[$];

  mouse_packet_ctrl #(
    .TIMEOUT_CYCLES (T_CYC),
    .PKT_GAP_CYCLES (G_CYC),
    .MAX_RETRIES    (RETRIES)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .tx_byte  (tx_byte),
    .tx_req   (tx_req),
    .tx_done  (tx_done),
    .dx       (dx),
    .dy       (dy),
    .m1       (m1),
    .m2       (m2),
    .m3       (m3),
    .new_data (new_data),
    .ready    (ready),
    .error    (error)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (new_data) pulses++;

  // Transceiver model: acknowledges each request after a short delay and logs the byte.
  always begin
    logic [7:0] b;
    @(posedge Clk); #1;
    if (tx_req && !Reset) begin
      b = tx_byte;
      repeat (2) begin @(posedge Clk); #1; end
      tx_done = 1'b1;
      @(posedge Clk); #1;
      tx_done = 1'b0;
      sent.push_back(b);
    end
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [8:0] dx, dy;
    logic [2:0] btn;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    rx_valid = 1'b1;
    rx_byte = a; tick(1);
    rx_byte = b; tick(1);
    rx_byte = c; tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_sent(input int n, input string name);
    int k = 0;
    while (sent.size() < n && k < 400) begin tick(1); k++; end
    check(name, sent.size(), n);
  endtask

  initial begin
    int p0;
    logic clamp;
`ifdef MOUSE_OVF_CLAMP_EN
    clamp = 1'b1;
`else
    clamp = 1'b0;
`endif
    vecs[0] = '{8'h09, 8'h05, 8'hFB, 9'h005, 9'h0FB, 3'b001};
    vecs[1] = '{8'h29, 8'h05, 8'hFB, 9'h005, 9'h1FB, 3'b001};
    vecs[2] = '{8'h1A, 8'h80, 8'h7F, 9'h180, 9'h07F, 3'b010};
    vecs[3] = '{8'h48, 8'h80, 8'h00, clamp ? 9'h0FF : 9'h080, 9'h000, 3'b000};
    vecs[4] = '{8'h8C, 8'h00, 8'h00, 9'h000, clamp ? 9'h0FF : 9'h000, 3'b100};
    vecs[5] = '{8'hF8, 8'h01, 8'h02, clamp ? 9'h100 : 9'h101, clamp ? 9'h100 : 9'h102, 3'b000};
    vecs[6] = '{8'h3F, 8'hFF, 8'h80, 9'h1FF, 9'h180, 3'b111};

    // Reset state
    tick(2);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_dxdy", {dx, dy}, 0);
    check("rst_flags", {m1, m2, m3, new_data, ready, error}, 0);
    Reset = 1'b0;
    tick(1);
    check("tx_req_first_cycle", tx_req, 1);

    // Init handshake
    wait_sent(1, "init_sent1");
    check("init_cmd_reset", sent[0], 8'hFF);
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    wait_sent(2, "init_sent2");
    check("init_cmd_enable", sent[1], 8'hF4);
    check("ready_before_ack", ready, 0);
    send_rx(8'hFA);
    check("ready_after_ack", ready, 1);
    check("error_after_init", error, 0);

    // Packet table, bytes back-to-back
    for (int i = 0; i < 7; i++) begin
      p0 = pulses;
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      tick(2);
      check($sformatf("vec%0d_dx", i), dx, vecs[i].dx);
      check($sformatf("vec%0d_dy", i), dy, vecs[i].dy);
      check($sformatf("vec%0d_btn", i), {m3, m2, m1}, vecs[i].btn);
      check($sformatf("vec%0d_pulses", i), pulses - p0, 1);
    end

    // Device hot-reset in B0
    sent.delete();
    send_rx(8'hAA);
    check("hot_ready", ready, 0);
    check("hot_btn", {m3, m2, m1}, 3'b000);
    check("hot_dx_held", dx, 9'h1FF);
    send_rx(8'h00);
    wait_sent(1, "hot_sent");
    check("hot_cmd_enable", sent[0], 8'hF4);
    send_rx(8'hFA);
    check("hot_ready_again", ready, 1);

    // Stray byte without bit 3 is dropped
    p0 = pulses;
    send_rx(8'h02);
    tick(1);
    send_pkt(8'h08, 8'h10, 8'h20);
    tick(2);
    check("stray_dx", dx, 9'h010);
    check("stray_dy", dy, 9'h020);
    check("stray_pulses", pulses - p0, 1);

    // Partial packet abandoned after gap
    p0 = pulses;
    send_rx(8'h08);
    send_rx(8'h01);
    tick(G_CYC + 5);
    check("gap_no_pulse", pulses - p0, 0);
    send_pkt(8'h08, 8'h02, 8'h03);
    tick(2);
    check("gap_dx", dx, 9'h002);
    check("gap_dy", dy, 9'h003);
    check("gap_pulses", pulses - p0, 1);

    // Retry exhaustion: one wrong byte, then silence
    Reset = 1'b1;
    #1;
    check("async_rst_ready", ready, 0);
    tick(2);
    sent.delete();
    Reset = 1'b0;
    wait_sent(1, "retry_sent1");
    send_rx(8'hFE);
    wait_sent(2, "retry_sent2");
    check("retry_no_error_yet", error, 0);
    begin
      int k = 0;
      while (!error && k < 400) begin tick(1); k++; end
    end
    tick(3);
    check("retry_error", error, 1);
    check("retry_tx_req", tx_req, 0);
    check("retry_ready", ready, 0);
    check("retry_send_count", sent.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < sent.size()) check($sformatf("retry_cmd%0d", i), sent[i], 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
